// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
// Purpose : Byte hand-off bundle between the UART receiver and its consumer.
//           The receiver (master) presents a byte with a valid/ready handshake
//           and reports framing and overrun errors as single-cycle pulses.
// Signals :
//   rx_ready     consumer -> receiver  accepts rx_data on a cycle with rx_valid=1
//   rx_data      receiver -> consumer  received byte, stable while rx_valid=1
//   rx_valid     receiver -> consumer  holding register full
//   frame_err    receiver -> consumer  1-cycle pulse, stop bit low, byte dropped
//   overrun_err  receiver -> consumer  1-cycle pulse, holding full, new byte dropped
// ----------------------------------------------------------------------------
interface uart_receiver_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;

  modport master (
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun_err
  );

  modport slave (
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun_err
  );
endinterface

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
// Purpose : 8N1 UART deserializer. Oversamples the asynchronous serial line at
//           OSR clocks per bit, receives LSB first, checks start/stop framing
//           and holds each byte in a single-entry output register handed off
//           through a valid/ready handshake.
// Parameters:
//   OSR          clocks per bit (even, >= 4)
//   SYNC_STAGES  flops in the serial-line synchronizer (>= 2)
// Ports   :
//   i_clk_rf       receive clock, OSR x baud rate
//   i_rst_rf_n     asynchronous active-low reset
//   i_receiver_rx  serial line, idle high, asynchronous to i_clk_rf
//   io_rx          byte hand-off bundle (master side)
// ----------------------------------------------------------------------------
module uart_receiver #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_rf,
  input  logic              i_rst_rf_n,
  input  logic              i_receiver_rx,
  uart_receiver_if.master   io_rx
);

  localparam int            CW        = $clog2(OSR);
  localparam logic [CW-1:0] HALF_LAST = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 r_state, w_stateNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxS;
  logic [CW-1:0]          r_cnt, w_cntNext;
  logic [2:0]             r_bitCnt, w_bitCntNext;
  logic [7:0]             r_shift, w_shiftNext;
  logic [7:0]             r_data, w_dataNext;
  logic                   r_valid, w_validNext;
  logic                   r_frameErr, w_frameErrNext;
  logic                   r_overrun, w_overrunNext;

  // Synchronizer resets to the idle-high level so release never looks like a start bit.
  always_ff @(posedge i_clk_rf or negedge i_rst_rf_n) begin
    if (!i_rst_rf_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_receiver_rx};
    end
  end

  assign w_rxS = r_sync[SYNC_STAGES-1];

  // State, counters and output registers all update together from the next-state logic.
  always_ff @(posedge i_clk_rf or negedge i_rst_rf_n) begin
    if (!i_rst_rf_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_bitCnt   <= w_bitCntNext;
      r_shift    <= w_shiftNext;
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_frameErr <= w_frameErrNext;
      r_overrun  <= w_overrunNext;
    end
  end

  // Next-state logic. The start bit is re-checked at its midpoint; from there every
  // full bit period lands the sample in the middle of the next bit. The stop
  // decision is taken mid-stop-bit so a back-to-back start still has half a bit of
  // margin. A transfer (valid & ready) empties the holding register unless a new
  // byte loads on the same edge.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_bitCntNext   = r_bitCnt;
    w_shiftNext    = r_shift;
    w_dataNext     = r_data;
    w_validNext    = r_valid & ~io_rx.rx_ready;
    w_frameErrNext = 1'b0;
    w_overrunNext  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rxS) begin
          w_stateNext = START;
          w_cntNext   = '0;
        end
      end

      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cntNext = '0;
          if (!w_rxS) begin
            w_stateNext  = DATA;
            w_bitCntNext = '0;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end

      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cntNext    = '0;
          w_shiftNext  = {w_rxS, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_stateNext = STOP;
          end
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end

      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cntNext = '0;
          if (w_rxS) begin
            w_stateNext = IDLE;
            if (!r_valid || io_rx.rx_ready) begin
              w_dataNext  = r_shift;
              w_validNext = 1'b1;
            end else begin
              w_overrunNext = 1'b1;
            end
          end else begin
            w_frameErrNext = 1'b1;
            w_stateNext    = BREAK;
          end
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end

      // A line held low after a bad stop bit must not start a new frame.
      BREAK: begin
        if (w_rxS) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  assign io_rx.rx_data     = r_data;
  assign io_rx.rx_valid    = r_valid;
  assign io_rx.frame_err   = r_frameErr;
  assign io_rx.overrun_err = r_overrun;

endmodule
